// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N:1 channel multiplexer.
//   state_t : operating state of the mux (idle, host-selected, auto-scan)
//   ch_lsb  : bit offset of a channel's slice inside the packed din bus
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Channel k of a packed bus with w bits per channel starts at bit k*w.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/scan_ptr_ctr.sv
// Channel pointer and dwell counter for the scanning multiplexer.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   load       : a select-load command is present this cycle (valid or not)
//   load_ok    : the command carries an in-range channel index
//   load_val   : channel index to load
//   dwell_clr  : restart the dwell count (scan mode being entered)
//   scan_on    : scan stepping is active this cycle
//   hold       : freeze pointer and dwell count while scanning
//   ch_ptr     : current channel pointer (always < NCH)
//   wrap_p1    : registered flag, high the cycle after the pointer wrapped to 0
module scan_ptr_ctr #(
  parameter int NCH   = 8,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            load_ok,
  input  logic [SELW-1:0] load_val,
  input  logic            dwell_clr,
  input  logic            scan_on,
  input  logic            hold,
  output logic [SELW-1:0] ch_ptr,
  output logic            wrap_p1
);

  localparam int              DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DEND = DW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [DW-1:0] dwell_cnt;
  logic          step_p0;
  logic          expire_p0;
  logic          wrap_p0;

  // A load command (even a rejected one) outranks hold, which outranks expiry.
  assign step_p0   = scan_on && !load && !hold;
  assign expire_p0 = step_p0 && (dwell_cnt == DEND);
  assign wrap_p0   = expire_p0 && (ch_ptr == LAST);

  // ---- stage p0 -> p1: pointer/dwell update and wrap flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ptr    <= '0;
      dwell_cnt <= '0;
      wrap_p1   <= 1'b0;
    end else begin
      wrap_p1 <= wrap_p0;
      if (load_ok) begin
        ch_ptr    <= load_val;
        dwell_cnt <= '0;
      end else if (dwell_clr) begin
        dwell_cnt <= '0;
      end else if (expire_p0) begin
        dwell_cnt <= '0;
        // Explicit wrap keeps the pointer below NCH for non-power-of-two NCH.
        ch_ptr    <= wrap_p0 ? '0 : ch_ptr + 1'b1;
      end else if (step_p0) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Parametrised N:1 channel multiplexer with registered, source-tagged output.
// Channels are picked either by a host-loaded select (manual) or by an internal
// pointer that dwells DWELL cycles on each channel in turn (scan).
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   din         : NCH packed channels, channel k at din[k*W +: W]
//   en          : block enable, 0 forces idle
//   mode        : 0 manual, 1 scan
//   sel_in      : channel index to load
//   sel_load    : one-cycle load strobe for sel_in
//   hold        : freeze scanning (pointer and dwell)
//   dout        : registered selected data
//   dout_valid  : dout carries a live sample
//   ch_out      : channel that produced dout
//   scan_wrap   : pulse with the first sample from channel 0 after a wrap
//   sel_err     : pulse after a load with an out-of-range index
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH*W-1:0] din,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel_in,
  input  logic            sel_load,
  input  logic            hold,
  output logic [W-1:0]    dout,
  output logic            dout_valid,
  output logic [SELW-1:0] ch_out,
  output logic            scan_wrap,
  output logic            sel_err
);

  localparam logic [SELW:0] NCH_V = (SELW + 1)'(NCH);

  state_t          state;
  state_t          next_state;
  logic            live_p0;
  logic            cmd_p0;
  logic            cmd_ok_p0;
  logic            scan_entry_p0;
  logic            scanning_p0;
  logic [SELW-1:0] ch_ptr;
  logic            wrap_p1;

  // Every state leaves for IDLE when disabled and otherwise follows mode.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE, MANUAL, SCAN: begin
        if (en) next_state = mode ? SCAN : MANUAL;
      end
      default: next_state = IDLE;
    endcase
  end

  assign live_p0       = (next_state != IDLE);
  assign scanning_p0   = (state == SCAN);
  assign cmd_p0        = sel_load && (state != IDLE);
  assign cmd_ok_p0     = cmd_p0 && ({1'b0, sel_in} < NCH_V);
  assign scan_entry_p0 = (state != SCAN) && (next_state == SCAN);

  scan_ptr_ctr #(
    .NCH   (NCH),
    .DWELL (DWELL),
    .SELW  (SELW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cmd_p0),
    .load_ok   (cmd_ok_p0),
    .load_val  (sel_in),
    .dwell_clr (scan_entry_p0),
    .scan_on   (scanning_p0),
    .hold      (hold),
    .ch_ptr    (ch_ptr),
    .wrap_p1   (wrap_p1)
  );

  // ---- stage p0 -> output: state, sample and tag registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      ch_out     <= '0;
      scan_wrap  <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state      <= next_state;
      dout_valid <= live_p0;
      sel_err    <= cmd_p0 && !cmd_ok_p0;
      // wrap_p1 lines up with the first sample taken from channel 0.
      scan_wrap  <= wrap_p1 && live_p0;
      // Sample uses the pointer before this cycle's update; idle holds the last sample.
      if (live_p0) begin
        dout   <= din[ch_lsb(int'(ch_ptr), W) +: W];
        ch_out <= ch_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
`timescale 1ns/1ps
module tb_mux_scan_nto1;

  localparam int NA = 8, WA = 1, DA = 4;
  localparam int NB = 6, WB = 4, DB = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en, mode, sel_load, hold;
  logic [2:0] sel_in;
  logic [NA*WA-1:0] din_a;
  logic [NB*WB-1:0] din_b;
  logic [WA-1:0] dout_a;
  logic [WB-1:0] dout_b;
  logic val_a, val_b, wrap_a, wrap_b, err_a, err_b;
  logic [2:0] ch_a, ch_b;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.NCH(NA), .W(WA), .DWELL(DA)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .en(en), .mode(mode),
    .sel_in(sel_in), .sel_load(sel_load), .hold(hold),
    .dout(dout_a), .dout_valid(val_a), .ch_out(ch_a),
    .scan_wrap(wrap_a), .sel_err(err_a));

  mux_scan_nto1 #(.NCH(NB), .W(WB), .DWELL(DB)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .en(en), .mode(mode),
    .sel_in(sel_in), .sel_load(sel_load), .hold(hold),
    .dout(dout_b), .dout_valid(val_b), .ch_out(ch_b),
    .scan_wrap(wrap_b), .sel_err(err_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 models u_a, index 1 models u_b.
  int nch [2] = '{NA, NB};
  int wid [2] = '{WA, WB};
  int dwl [2] = '{DA, DB};
  bit m_on [2];
  bit m_scan [2];
  bit m_wp [2];
  int m_ptr [2];
  int m_dw [2];
  logic [31:0] e_dout [2];
  int e_ch [2];
  bit e_val [2];
  bit e_wrap [2];
  bit e_err [2];

  function automatic logic [31:0] chan(input int i, input int k);
    logic [31:0] v;
    v = (i == 0) ? 32'(din_a) : 32'(din_b);
    return (v >> (k * wid[i])) & ((32'd1 << wid[i]) - 32'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_on[i] = 0; m_scan[i] = 0; m_wp[i] = 0; m_ptr[i] = 0; m_dw[i] = 0;
      e_dout[i] = 0; e_ch[i] = 0; e_val[i] = 0; e_wrap[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("a_dout",  32'(dout_a), e_dout[0]);
    chk("a_ch",    32'(ch_a),   32'(e_ch[0]));
    chk("a_valid", 32'(val_a),  32'(e_val[0]));
    chk("a_wrap",  32'(wrap_a), 32'(e_wrap[0]));
    chk("a_err",   32'(err_a),  32'(e_err[0]));
    chk("b_dout",  32'(dout_b), e_dout[1]);
    chk("b_ch",    32'(ch_b),   32'(e_ch[1]));
    chk("b_valid", 32'(val_b),  32'(e_val[1]));
    chk("b_wrap",  32'(wrap_b), 32'(e_wrap[1]));
    chk("b_err",   32'(err_b),  32'(e_err[1]));
  endtask

  // Advance one clock: predict from the inputs present at the edge, then compare.
  task automatic tick();
    bit n_on [2], n_scan [2], n_wp [2];
    int n_ptr [2], n_dw [2];
    logic [31:0] x_dout [2];
    int x_ch [2];
    bit x_val [2], x_wrap [2], x_err [2];
    bit ld, ok;
    for (int i = 0; i < 2; i++) begin
      ld = m_on[i] && sel_load;
      ok = int'(sel_in) < nch[i];
      n_on[i] = en; n_scan[i] = en && mode;
      n_ptr[i] = m_ptr[i]; n_dw[i] = m_dw[i]; n_wp[i] = 0;
      x_dout[i] = e_dout[i]; x_ch[i] = e_ch[i];
      if (en) begin
        x_dout[i] = chan(i, m_ptr[i]);
        x_ch[i] = m_ptr[i];
      end
      x_val[i] = en;
      x_wrap[i] = en && m_wp[i];
      x_err[i] = ld && !ok;
      if (ld && ok) begin
        n_ptr[i] = int'(sel_in); n_dw[i] = 0;
      end else if (n_scan[i] && !m_scan[i]) begin
        n_dw[i] = 0;
      end else if (m_scan[i] && !ld && !hold) begin
        if (m_dw[i] == dwl[i] - 1) begin
          n_dw[i] = 0;
          n_wp[i] = (m_ptr[i] == nch[i] - 1);
          n_ptr[i] = (m_ptr[i] + 1) % nch[i];
        end else begin
          n_dw[i] = m_dw[i] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_on[i] = n_on[i]; m_scan[i] = n_scan[i]; m_wp[i] = n_wp[i];
        m_ptr[i] = n_ptr[i]; m_dw[i] = n_dw[i];
        e_dout[i] = x_dout[i]; e_ch[i] = x_ch[i]; e_val[i] = x_val[i];
        e_wrap[i] = x_wrap[i]; e_err[i] = x_err[i];
      end
    end
    cmp_all();
  endtask

  initial begin
    bit seen;
    bit hit;

    // Reset state
    rst_n = 1'b0; en = 0; mode = 0; sel_in = 0; sel_load = 0; hold = 0;
    din_a = '0; din_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
    tick();

    // Manual select of channel 5
    en = 1; mode = 0; din_a = 8'b1010_0110; din_b = 24'($urandom);
    tick();
    sel_in = 3'd5; sel_load = 1; tick();
    sel_load = 0; tick();
    chk("a_ld5_dout", 32'(dout_a), 32'd1);
    chk("a_ld5_ch", 32'(ch_a), 32'd5);
    chk("a_ld5_valid", 32'(val_a), 32'd1);

    // Scan from channel 5 until the wrap pulse
    mode = 1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      din_a = 8'($urandom); din_b = 24'($urandom);
      tick();
      chk("b_ch_range", 32'(ch_b < 3'd6), 32'd1);
      if (wrap_a) begin
        seen = 1;
        chk("a_wrap_ch0", 32'(ch_a), 32'd0);
      end
    end
    chk("a_wrap_seen", 32'(seen), 32'd1);

    // Hold mid-dwell on channel 2
    hit = 0;
    for (int k = 0; k < 30; k++) begin
      if (m_ptr[0] == 2 && m_dw[0] == 1) begin hit = 1; break; end
      tick();
      chk("b_ch_range", 32'(ch_b < 3'd6), 32'd1);
    end
    chk("a_hold_reached", 32'(hit), 32'd1);
    hold = 1;
    for (int k = 0; k < 10; k++) begin
      din_a = din_a ^ 8'h04;
      tick();
      chk("a_hold_ch", 32'(ch_a), 32'd2);
    end
    hold = 0;
    for (int k = 0; k < 6; k++) tick();

    // Out-of-range load on the 6-channel instance
    mode = 0; tick();
    sel_in = 3'd7; sel_load = 1; tick();
    chk("b_err_pulse", 32'(err_b), 32'd1);
    sel_load = 0; tick();
    chk("b_err_clear", 32'(err_b), 32'd0);

    // Load coinciding with dwell expiry at channel 7
    mode = 1;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_scan[0] && m_ptr[0] == 7 && m_dw[0] == DA - 1) begin hit = 1; break; end
      tick();
    end
    chk("a_expiry_reached", 32'(hit), 32'd1);
    sel_in = 3'd3; sel_load = 1; tick();
    sel_load = 0;
    for (int k = 0; k < DA; k++) begin
      tick();
      chk("a_ld3_ch", 32'(ch_a), 32'd3);
      chk("a_ld3_nowrap", 32'(wrap_a), 32'd0);
    end
    tick();
    chk("a_ld3_next", 32'(ch_a), 32'd4);

    // Asynchronous reset in the middle of a scan
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("a_rst_restart_ch", 32'(ch_a), 32'd0);
    chk("a_rst_restart_valid", 32'(val_a), 32'd1);
    for (int k = 0; k < 8; k++) tick();

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 15) != 0);
      mode = ($urandom_range(0, 3) != 0);
      sel_load = ($urandom_range(0, 9) == 0);
      sel_in = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 5) == 0);
      din_a = 8'($urandom);
      din_b = 24'($urandom);
      tick();
      chk("b_ch_range", 32'(ch_b < 3'd6), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
